// File: rtl/mccoy_pkg.sv
// Shared types and constants for the McCoy program-sequencing controller.
package mccoy_pkg;
   localparam int MCCOY_AW = 6;
   localparam int MCCOY_IW = 6;
   localparam logic [MCCOY_IW-1:0] MCCOY_FILL = 6'h00;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_LOAD = 3'd1,
      ST_RUN  = 3'd2,
      ST_STEP = 3'd3,
      ST_HALT = 3'd4
   } state_e;
endpackage

// File: rtl/mccoy_prog_mem.sv
// Instruction buffer: one synchronous write port, one asynchronous read port, contents not reset.
module mccoy_prog_mem #(
   parameter int DEPTH = 64,
   parameter int AW    = 6,
   parameter int IW    = 6
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [IW-1:0] wdata,
   input  logic [AW-1:0] raddr,
   output logic [IW-1:0] rdata
);
   logic [IW-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem_q[waddr] <= wdata;
   end

   assign rdata = mem_q[raddr];
endmodule

// File: rtl/mccoy_prog_ctrl.sv
// Program-sequencing controller: loads the instruction buffer and sequences the core
// through load / run / single-step / halt / breakpoint modes via core_step.
module mccoy_prog_ctrl
   import mccoy_pkg::*;
#(
   parameter int             DEPTH = 64,
   parameter int             AW    = MCCOY_AW,
   parameter int             IW    = MCCOY_IW,
   parameter int             CW    = 8,
   parameter logic [IW-1:0]  FILL  = MCCOY_FILL
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          load_en,
   input  logic          wr_valid,
   input  logic [IW-1:0] wr_data,
   output logic          wr_ready,
   input  logic          run,
   input  logic          step,
   input  logic          halt_req,
   input  logic          bp_en,
   input  logic [AW-1:0] bp_addr,
   input  logic [AW-1:0] core_pc,
   output logic          core_reset,
   output logic          core_step,
   output logic [IW-1:0] instr,
   output logic [2:0]    state,
   output logic [CW-1:0] cycles,
   output logic [AW:0]   load_count
);
   localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

   state_e        state_q, state_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW:0]   load_count_q, load_count_d;
   logic [CW-1:0] cycles_q, cycles_d;
   logic          bp_skip_q, bp_skip_d;
   logic          bp_hit, wr_fire, enter_load;
   logic [IW-1:0] mem_rdata;

   always_comb begin
      state_d      = state_q;
      wr_ptr_d     = wr_ptr_q;
      load_count_d = load_count_q;
      cycles_d     = cycles_q;
      bp_skip_d    = 1'b0;
      core_step    = 1'b0;
      wr_ready     = 1'b0;
      bp_hit       = 1'b0;
      wr_fire      = 1'b0;
      enter_load   = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (load_en)   enter_load = 1'b1;
            else if (run)  state_d = ST_RUN;
            else if (step) state_d = ST_STEP;
         end
         ST_LOAD: begin
            wr_ready = (load_count_q < DEPTH_L);
            wr_fire  = wr_valid & wr_ready;
            if (!load_en) state_d = ST_IDLE;
         end
         ST_RUN: begin
            // bp_skip lets a resume step over the breakpoint it stopped at
            bp_hit    = bp_en & (core_pc == bp_addr) & ~bp_skip_q;
            core_step = ~halt_req & ~bp_hit;
            if (load_en)                  enter_load = 1'b1;
            else if (halt_req || bp_hit)  state_d = ST_HALT;
         end
         ST_STEP: begin
            core_step = 1'b1;
            state_d   = ST_HALT;
         end
         ST_HALT: begin
            if (load_en) enter_load = 1'b1;
            else if (run) begin
               state_d   = ST_RUN;
               bp_skip_d = 1'b1;
            end
            else if (step) state_d = ST_STEP;
         end
         default: state_d = ST_IDLE;
      endcase

      if (wr_fire) begin
         wr_ptr_d     = wr_ptr_q + 1'b1;
         load_count_d = load_count_q + 1'b1;
      end
      if (core_step && (cycles_q != {CW{1'b1}})) cycles_d = cycles_q + 1'b1;

      // entering LOAD restarts the buffer fill and the executed-instruction count
      if (enter_load) begin
         state_d      = ST_LOAD;
         wr_ptr_d     = '0;
         load_count_d = '0;
         cycles_d     = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         wr_ptr_q     <= '0;
         load_count_q <= '0;
         cycles_q     <= '0;
         bp_skip_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         wr_ptr_q     <= wr_ptr_d;
         load_count_q <= load_count_d;
         cycles_q     <= cycles_d;
         bp_skip_q    <= bp_skip_d;
      end
   end

   mccoy_prog_mem #(
      .DEPTH (DEPTH),
      .AW    (AW),
      .IW    (IW)
   ) u_mem (
      .clk   (clk),
      .we    (wr_fire & ~reset),
      .waddr (wr_ptr_q),
      .wdata (wr_data),
      .raddr (core_pc),
      .rdata (mem_rdata)
   );

   assign instr      = ({1'b0, core_pc} < load_count_q) ? mem_rdata : FILL;
   assign core_reset = (state_q == ST_IDLE) || (state_q == ST_LOAD);
   assign state      = state_q;
   assign cycles     = cycles_q;
   assign load_count = load_count_q;
endmodule

// File: tb/tb_mccoy_prog_ctrl.sv
// Directed bench for mccoy_prog_ctrl with a behavioural controller + core model checked every cycle.
module tb_mccoy_prog_ctrl;
   logic       clk;
   logic       reset;
   logic       load_en, wr_valid, run, step, halt_req, bp_en;
   logic [5:0] wr_data, bp_addr, core_pc;
   logic       wr_ready, core_reset, core_step;
   logic [5:0] instr;
   logic [2:0] state;
   logic [7:0] cycles;
   logic [6:0] load_count;

   logic       pc_force_en;
   logic [5:0] pc_force_val;
   logic [5:0] m_pc;

   int n_checks = 0;
   int n_err    = 0;

   localparam int S_IDLE = 0, S_LOAD = 1, S_RUN = 2, S_STEP = 3, S_HALT = 4;

   // model state
   int         m_state;
   int         m_lcnt;
   int         m_cyc;
   bit         m_skip;
   bit         m_init = 0;
   logic [5:0] m_mem [64];

   assign core_pc = pc_force_en ? pc_force_val : m_pc;

   mccoy_prog_ctrl dut (
      .clk        (clk),
      .reset      (reset),
      .load_en    (load_en),
      .wr_valid   (wr_valid),
      .wr_data    (wr_data),
      .wr_ready   (wr_ready),
      .run        (run),
      .step       (step),
      .halt_req   (halt_req),
      .bp_en      (bp_en),
      .bp_addr    (bp_addr),
      .core_pc    (core_pc),
      .core_reset (core_reset),
      .core_step  (core_step),
      .instr      (instr),
      .state      (state),
      .cycles     (cycles),
      .load_count (load_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit exp_step();
      bit hit;
      hit = bp_en && (core_pc == bp_addr) && !m_skip;
      return (m_state == S_STEP) || (m_state == S_RUN && !halt_req && !hit);
   endfunction

   function automatic logic [5:0] exp_instr();
      return (int'(core_pc) < m_lcnt) ? m_mem[core_pc] : 6'h00;
   endfunction

   // Behavioural model of controller + a core whose PC advances on each enabled step
   always @(posedge clk) begin
      bit stp, hit, in_reset_mode, go_load;
      stp           = m_init && exp_step();
      in_reset_mode = (m_state == S_IDLE) || (m_state == S_LOAD);
      hit           = bp_en && (core_pc == bp_addr) && !m_skip;
      if (m_init) m_pc <= in_reset_mode ? 6'd0 : m_pc + 6'(stp);
      if (reset) begin
         m_state = S_IDLE; m_lcnt = 0; m_cyc = 0; m_skip = 0; m_init = 1;
      end else if (m_init) begin
         go_load = 0;
         m_skip  = 0;
         if (stp && m_cyc < 255) m_cyc++;
         case (m_state)
            S_IDLE: if (load_en) go_load = 1; else if (run) m_state = S_RUN; else if (step) m_state = S_STEP;
            S_LOAD: begin
               if (wr_valid && m_lcnt < 64) begin
                  m_mem[m_lcnt] = wr_data;
                  m_lcnt++;
               end
               if (!load_en) m_state = S_IDLE;
            end
            S_RUN:  if (load_en) go_load = 1; else if (halt_req || hit) m_state = S_HALT;
            S_STEP: m_state = S_HALT;
            S_HALT: begin
               if (load_en) go_load = 1;
               else if (run) begin m_state = S_RUN; m_skip = 1; end
               else if (step) m_state = S_STEP;
            end
            default: m_state = S_IDLE;
         endcase
         if (go_load) begin m_state = S_LOAD; m_lcnt = 0; m_cyc = 0; end
      end
   end

   initial m_pc = 6'd0;

   // Per-cycle comparison against the model
   always @(negedge clk) begin
      if (m_init) begin
         chk("state",      state,      m_state);
         chk("core_reset", core_reset, (m_state == S_IDLE || m_state == S_LOAD));
         chk("core_step",  core_step,  exp_step());
         chk("wr_ready",   wr_ready,   (m_state == S_LOAD && m_lcnt < 64));
         chk("instr",      instr,      exp_instr());
         chk("cycles",     cycles,     m_cyc);
         chk("load_count", load_count, m_lcnt);
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic load_words(input int n, input logic [5:0] base);
      load_en = 1'b1;
      cyc();
      for (int i = 0; i < n; i++) begin
         wr_valid = 1'b1;
         wr_data  = (i >= 64) ? 6'h00 : base + 6'(i);
         if (i == n - 1) load_en = 1'b0;
         cyc();
      end
      wr_valid = 1'b0;
      load_en  = 1'b0;
   endtask

   initial begin
      reset = 1'b1; load_en = 0; wr_valid = 0; wr_data = 0; run = 0; step = 0;
      halt_req = 0; bp_en = 0; bp_addr = 0; pc_force_en = 0; pc_force_val = 0;
      cyc(); cyc();
      chk("rst_state", state, 0);
      chk("rst_core_reset", core_reset, 1);
      chk("rst_core_step", core_step, 0);
      chk("rst_wr_ready", wr_ready, 0);
      chk("rst_cycles", cycles, 0);
      chk("rst_load_count", load_count, 0);
      chk("rst_instr", instr, 6'h00);
      reset = 1'b0;
      cyc();

      // 1: small load, last word written in the cycle load_en drops
      load_words(5, 6'h01);
      chk("t1_load_count", load_count, 5);
      chk("t1_state", state, 0);
      chk("t1_core_reset", core_reset, 1);
      pc_force_en = 1; pc_force_val = 6'd2; #1;
      chk("t1_instr_pc2", instr, 6'h03);
      pc_force_val = 6'd7; #1;
      chk("t1_instr_pc7", instr, 6'h00);
      pc_force_en = 0;
      cyc();

      // 2: overfill; words 65 and 66 must be dropped
      load_words(66, 6'h05);
      chk("t2_load_count", load_count, 64);
      pc_force_en = 1; pc_force_val = 6'd0; #1;
      chk("t2_mem0", instr, 6'h05);
      pc_force_val = 6'd63; #1;
      chk("t2_mem63", instr, 6'h04);
      pc_force_en = 0;
      cyc();

      // 3: run into a breakpoint at PC 4
      load_words(10, 6'h20);
      cyc();
      bp_en = 1; bp_addr = 6'd4; run = 1;
      cyc();
      run = 0;
      for (int n = 0; n < 30 && state !== 3'd4; n++) cyc();
      chk("t3_state_halt", state, 4);
      chk("t3_pc", core_pc, 4);
      chk("t3_cycles", cycles, 4);
      cyc();
      chk("t3_held_pc", core_pc, 4);

      // 4: resume steps over the breakpoint
      run = 1;
      cyc();
      run = 0;
      chk("t4_state_run", state, 2);
      chk("t4_instr_pc4", instr, 6'h24);
      cyc();
      chk("t4_cycles", cycles, 5);
      chk("t4_pc", core_pc, 5);
      cyc(); cyc(); cyc();
      halt_req = 1;
      cyc();
      halt_req = 0;
      chk("t4_halt_state", state, 4);
      chk("t4_halt_cycles", cycles, 8);
      chk("t4_halt_pc", core_pc, 8);

      // 5: single step, then step+run together
      step = 1;
      cyc();
      step = 0;
      chk("t5_state_step", state, 3);
      chk("t5_core_step", core_step, 1);
      cyc();
      chk("t5_state_halt", state, 4);
      chk("t5_cycles", cycles, 9);
      step = 1; run = 1;
      cyc();
      step = 0; run = 0; halt_req = 1;
      chk("t5_run_wins", state, 2);
      cyc();
      halt_req = 0;
      chk("t5_halt_again", state, 4);
      chk("t5_cycles2", cycles, 9);
      // halt_req coincident with a breakpoint hit at PC 12
      bp_addr = 6'd12; run = 1;
      cyc();
      run = 0;
      cyc(); cyc(); cyc();
      chk("t5_at_bp_pc", core_pc, 12);
      halt_req = 1;
      cyc();
      chk("t5_bp_halt_state", state, 4);
      chk("t5_bp_halt_pc", core_pc, 12);
      chk("t5_bp_halt_cycles", cycles, 12);
      cyc();
      halt_req = 0;
      chk("t5_halt_ignored", state, 4);

      // 6: reset mid-run, then saturation
      bp_en = 0; run = 1;
      cyc();
      run = 0;
      cyc(); cyc();
      reset = 1;
      cyc();
      reset = 0;
      chk("t6_rst_state", state, 0);
      chk("t6_rst_core_reset", core_reset, 1);
      chk("t6_rst_cycles", cycles, 0);
      chk("t6_rst_load_count", load_count, 0);
      chk("t6_rst_instr", instr, 6'h00);
      cyc();
      run = 1;
      cyc();
      run = 0;
      for (int i = 0; i < 300; i++) cyc();
      chk("t6_saturate", cycles, 255);
      halt_req = 1;
      cyc();
      halt_req = 0;
      chk("t6_sat_hold", cycles, 255);
      // reset discards an in-flight write
      load_en = 1;
      cyc();
      wr_valid = 1; wr_data = 6'h11; reset = 1;
      cyc();
      reset = 0; wr_valid = 0; load_en = 0;
      chk("t6_write_discard", load_count, 0);
      cyc(); cyc();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end
endmodule
